// File: rtl/fifo_prog_if.sv
// Data handshake between the sample producers, the FIFO and the readout consumer.
// The master side is the producer/consumer pair; the slave side is the FIFO itself.
interface fifo_prog_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_data_vld;
    logic                  out_data_vld;
    logic                  out_data_rdy;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_data,
        output in_data_vld,
        output out_data_vld,
        input  out_data_rdy,
        input  out_data
    );

    modport slave (
        input  in_data,
        input  in_data_vld,
        input  out_data_vld,
        output out_data_rdy,
        output out_data
    );
endinterface

// File: rtl/fifo_prog.sv
// First-word-fall-through FIFO of arbitrary depth, with programmable almost thresholds,
// selectable overflow policy, sticky error events and a saturating overflow counter.
module fifo_prog #(
    parameter  int DATA_WIDTH      = 32,
    parameter  int FIFO_SIZE       = 5,
    parameter  int CNT_WIDTH       = 16,
    localparam int FIFO_SIZE_WIDTH = $clog2(FIFO_SIZE)
) (
    input  logic                       clk,
    input  logic                       rstn,
    fifo_prog_if.slave                 bus,
    output logic [FIFO_SIZE_WIDTH-1:0] out_data_ptr,
    output logic [FIFO_SIZE_WIDTH:0]   fifo_size,
    output logic                       full,
    output logic                       empty,
    input  logic [FIFO_SIZE_WIDTH:0]   cfg_af_th,
    input  logic [FIFO_SIZE_WIDTH:0]   cfg_ae_th,
    output logic                       almost_full,
    output logic                       almost_empty,
    input  logic                       cfg_overwrite,
    input  logic                       flush_fifo,
    input  logic                       event_clr,
    output logic                       event_overflow,
    output logic                       event_underrun,
    output logic [CNT_WIDTH-1:0]       overflow_cnt
);
    localparam int SIZE_W = FIFO_SIZE_WIDTH + 1;
    localparam logic [FIFO_SIZE_WIDTH-1:0] LAST_PTR  = FIFO_SIZE_WIDTH'(FIFO_SIZE - 1);
    localparam logic [SIZE_W-1:0]          SIZE_FULL = SIZE_W'(FIFO_SIZE);

    logic [DATA_WIDTH-1:0]      mem [FIFO_SIZE];
    logic [FIFO_SIZE_WIDTH-1:0] wr_ptr;
    logic [FIFO_SIZE_WIDTH-1:0] rd_ptr;
    logic [SIZE_W-1:0]          size_q;

    logic rd_ok;
    logic wr_ok;
    logic underrun;
    logic overflow;
    logic overwrite;
    logic mem_we;
    logic rd_adv;

    // Depth need not be a power of two, so the wrap is an explicit compare.
    function automatic logic [FIFO_SIZE_WIDTH-1:0] ptr_inc(input logic [FIFO_SIZE_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign fifo_size        = size_q;
    assign full             = (size_q == SIZE_FULL);
    assign empty            = (size_q == '0);
    assign almost_full      = (size_q >= cfg_af_th);
    assign almost_empty     = (size_q <= cfg_ae_th);
    assign out_data_ptr     = rd_ptr;
    assign bus.out_data     = mem[rd_ptr];
    assign bus.out_data_rdy = !empty;

    // A pop only sees words present before the edge, so a write into an empty FIFO
    // cannot satisfy a same-cycle read; a pop does free a slot for a same-cycle write.
    always_comb begin
        rd_ok     = bus.out_data_vld && !empty;
        underrun  = bus.out_data_vld && empty;
        wr_ok     = bus.in_data_vld && (!full || rd_ok);
        overflow  = bus.in_data_vld && full && !rd_ok;
        overwrite = overflow && cfg_overwrite;
        mem_we    = !flush_fifo && (wr_ok || overwrite);
        rd_adv    = !flush_fifo && (rd_ok || overwrite);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            size_q <= '0;
        end else if (flush_fifo) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            size_q <= '0;
        end else begin
            if (mem_we) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_adv) rd_ptr <= ptr_inc(rd_ptr);
            if (wr_ok && !rd_ok)      size_q <= size_q + 1'b1;
            else if (rd_ok && !wr_ok) size_q <= size_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr] <= bus.in_data;
    end

    // A new error on the same edge beats a clear; flush leaves the error state alone.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            event_overflow <= 1'b0;
            event_underrun <= 1'b0;
            overflow_cnt   <= '0;
        end else if (!flush_fifo) begin
            if (overflow)       event_overflow <= 1'b1;
            else if (event_clr) event_overflow <= 1'b0;
            if (underrun)       event_underrun <= 1'b1;
            else if (event_clr) event_underrun <= 1'b0;
            if (overflow && (overflow_cnt != '1)) overflow_cnt <= overflow_cnt + 1'b1;
        end
    end
endmodule

// File: doc/fifo_prog.md
# fifo_prog

Parametrised successor to the data-path FIFO: synchronous first-word-fall-through buffer with configurable data width and arbitrary (non-power-of-2) depth. It adds programmable almost-full/almost-empty thresholds, a selectable overflow policy (drop-newest or overwrite-oldest), sticky error events with explicit clear, and a saturating overflow counter. It sits between the sample producers and the readout path, where firmware tunes thresholds at run time.

## Interface
- DATA_WIDTH, 32, data word width
- FIFO_SIZE, 5, depth in words, any integer >= 2; FIFO_SIZE_WIDTH = $clog2(FIFO_SIZE)
- CNT_WIDTH, 16, overflow counter width
- clk  input  1  single clock, all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- in_data  input  DATA_WIDTH  write data
- in_data_vld  input  1  write request
- out_data_vld  input  1  read (pop) request from consumer
- out_data_rdy  output  1  head word valid (= !empty)
- out_data  output  DATA_WIDTH  head word, FWFT
- out_data_ptr  output  FIFO_SIZE_WIDTH  current read pointer
- fifo_size  output  FIFO_SIZE_WIDTH+1  occupancy, 0..FIFO_SIZE
- full, empty  output  1 each  fifo_size==FIFO_SIZE / fifo_size==0
- cfg_af_th, cfg_ae_th  input  FIFO_SIZE_WIDTH+1 each  almost-full / almost-empty thresholds
- almost_full, almost_empty  output  1 each  fifo_size>=cfg_af_th / fifo_size<=cfg_ae_th
- cfg_overwrite  input  1  0 = drop newest on overflow, 1 = overwrite oldest
- flush_fifo  input  1  synchronous flush
- event_clr  input  1  clears sticky events
- event_overflow, event_underrun  output  1 each  sticky error flags
- overflow_cnt  output  CNT_WIDTH  saturating count of overflow cycles

## Operation
- Storage: FIFO_SIZE x DATA_WIDTH register array; write pointer, read pointer, occupancy counter.
- Pointers increment mod FIFO_SIZE: at FIFO_SIZE-1 next value is 0 (explicit wrap, not bit overflow).
- out_data = mem[rd_ptr] combinationally; value undefined-but-stable (last content) when empty.
- Per-cycle priority: flush > normal.
- Flush: both pointers and fifo_size to 0; same-cycle write and read ignored; no events raised; overflow_cnt, events unchanged.
- Write accepted if in_data_vld and (!full or read accepted same cycle).
- Read accepted if out_data_vld and !empty; reads only words present before the edge.
- Read+write, non-empty: both accepted, size unchanged.
- Read+write, empty: write accepted, read is underrun.
- Read when empty: no pointer/size change, event_underrun set.
- Write when full, no read: overflow. event_overflow set, overflow_cnt+1 (holds at all-ones).
  - cfg_overwrite=0: word discarded, state unchanged.
  - cfg_overwrite=1: word written at wr_ptr (=rd_ptr), both pointers advance, size stays FIFO_SIZE; oldest word lost.
- Events: set wins over event_clr in the same cycle; otherwise event_clr clears both flags (counter not cleared).
- Thresholds sampled every cycle; changes take effect on status combinationally against current fifo_size.
- cfg_af_th=0 forces almost_full=1; cfg_ae_th>=FIFO_SIZE forces almost_empty=1; no error.

## Timing
- Reset (async assert, sync to clk on release): pointers, fifo_size, events, overflow_cnt = 0; out_data_ptr=0; empty=1, full=0, out_data_rdy=0; memory not reset, out_data undefined until first write.
- Write latency: word visible on out_data and out_data_rdy=1 the cycle after the accepting edge.
- Read latency: next head appears the cycle after the popping edge.
- fifo_size, full, empty, almost_* reflect registered occupancy; update one edge after the event.
- Events and counter update on the same edge as the offending request.
- Reset mid-operation clears immediately regardless of in-flight requests.

## Test plan
- Reset with cfg_ae_th=1, cfg_af_th=4 -> fifo_size=0, empty=1, almost_empty=1, almost_full=0, events 0, overflow_cnt=0.
- Write 1,2; then write 3 with read -> popped 1, fifo_size stays 2, out_data=2 next; read twice -> 2 then 3, empty=1.
- cfg_overwrite=0: write 4..8 (full=1, almost_full=1 at size 4), write 9 -> event_overflow=1, overflow_cnt=1, reads return 4,5,6,7,8.
- cfg_overwrite=1: write 4..8, write 9 -> size 5, reads return 5,6,7,8,9; out_data_ptr wraps 4->0.
- Read on empty -> event_underrun=1, size 0, ptr unchanged; event_clr -> 0; event_clr with simultaneous underrun -> stays 1.
- Flush with concurrent write of 0xA at size 3 -> size 0 next cycle, 0xA not stored; assert rstn low mid-burst -> all outputs at reset values immediately.
